// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle key events (press, release,
// click, long-press, auto-repeat) plus a held level. All outputs are registered.
module button_event #(
  parameter int CW         = 24,
  parameter int LONG_TICKS = 5000000,
  parameter int RPT_TICKS  = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_TICKS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          click_q, click_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A button already down when reset lifts must be let go before it counts.
        if (!db_in) begin
          armed_d = 1'b1;
        end
        if (armed_q && db_in) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        // Release is tested first so it wins over a coincident terminal count.
        if (!db_in) begin
          release_d = 1'b1;
          click_d   = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!db_in) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == RPT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == PRESS) || (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: each driven db_in sample queues the output
// vector expected after the next clock edge; a monitor pops and compares.
module tb_button_event;

  localparam int CW         = 8;
  localparam int LONG_TICKS = 8;
  localparam int RPT_TICKS  = 4;

  // Expected vector layout: {held, press, release, click, long, repeat}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] H  = 6'b100000;
  localparam logic [5:0] P  = 6'b010000;
  localparam logic [5:0] R  = 6'b001000;
  localparam logic [5:0] C  = 6'b000100;
  localparam logic [5:0] L  = 6'b000010;
  localparam logic [5:0] RP = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_in = 1'b0;
  logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [5:0] exp_q[$];

  button_event #(
    .CW(CW),
    .LONG_TICKS(LONG_TICKS),
    .RPT_TICKS(RPT_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .db_in(db_in),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .click_pulse(click_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {held, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
  endfunction

  // Monitor: compare one queued expectation per clock edge.
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      step_no++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL step%0d {held,press,rel,click,long,rpt} got %b expected %b",
                 step_no, outs(), e);
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] e);
    @(negedge clk);
    db_in = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic direct_check(input string name, input logic [5:0] e);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, outs(), e);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    direct_check("reset_state", Z);
    reset = 1'b0;

    // Arm
    step(1'b0, Z);
    step(1'b0, Z);

    // Short click: 5 samples high
    step(1'b1, H | P);
    for (int k = 1; k <= 4; k++) step(1'b1, H);
    step(1'b0, R | C);
    step(1'b0, Z);

    // Long hold: long at +8, repeats at +12/+16/+20, release without click
    for (int k = 0; k <= 20; k++) begin
      logic [5:0] e;
      e = H;
      if (k == 0) e = e | P;
      if (k == 8) e = e | L;
      if (k == 12 || k == 16 || k == 20) e = e | RP;
      step(1'b1, e);
    end
    step(1'b0, R);
    step(1'b0, Z);

    // Release exactly on the terminal-count edge
    step(1'b1, H | P);
    for (int k = 1; k <= 7; k++) step(1'b1, H);
    step(1'b0, R | C);
    step(1'b0, Z);
    step(1'b0, Z);

    // Held through reset: no press until db_in has been seen low
    drain();
    reset = 1'b1;
    db_in = 1'b1;
    repeat (2) @(negedge clk);
    direct_check("in_reset_held_button", Z);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b1, Z);
    step(1'b0, Z);
    step(1'b1, H | P);
    step(1'b0, R | C);
    step(1'b0, Z);

    // Reset two cycles after long_pulse
    step(1'b1, H | P);
    for (int k = 1; k <= 10; k++) step(1'b1, (k == 8) ? (H | L) : H);
    drain();
    #1;
    reset = 1'b1;
    #1;
    direct_check("async_reset_mid_hold", Z);
    @(negedge clk);
    direct_check("reset_mid_hold_no_release", Z);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    direct_check("after_reset_still_held", Z);
    step(1'b1, Z);
    step(1'b0, Z);

    // Back-to-back presses: 1,1,1,0,1,1,0
    step(1'b1, H | P);
    step(1'b1, H);
    step(1'b1, H);
    step(1'b0, R | C);
    step(1'b1, H | P);
    step(1'b1, H);
    step(1'b0, R | C);
    step(1'b0, Z);

    drain();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached expected finish");
    $fatal(1, "timeout");
  end

endmodule
